// File: rtl/wb_cache_ctrl.sv
// Direct-mapped, one-word-per-line write-back cache controller.
// A CPU request is latched in IDLE and compared against the tag store.
// Dirty victims are written back before a read refill or a write install.
// A flush scans every index and writes back each dirty line.
module wb_cache_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_hit,
  output logic [31:0] cpu_rdata,
  input  logic        flush,
  output logic        flush_done,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int IDX   = $clog2(DEPTH);
  localparam int TAG_W = 30 - IDX;
  localparam logic [IDX-1:0] LAST_IDX = IDX'(DEPTH - 1);
  localparam logic [IDX-1:0] ONE_IDX  = IDX'(1);

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, FLUSH, DONE} state_t;

  state_t             state_r;
  logic               req_we_r;
  logic [29:0]        req_word_r;
  logic [31:0]        req_wdata_r;
  logic               hit_r;
  logic [31:0]        rd_buf_r;
  logic               flushing_r;
  logic [IDX-1:0]     flush_idx_r;
  logic [DEPTH-1:0]   valid_r;
  logic [DEPTH-1:0]   dirty_r;
  logic [TAG_W-1:0]   tag_mem_r [DEPTH];
  logic [31:0]        data_mem_r [DEPTH];

  logic               cpu_ready_r, cpu_hit_r, flush_done_r, busy_r;
  logic               mem_req_r, mem_we_r;
  logic [31:0]        cpu_rdata_r, mem_addr_r, mem_wdata_r;

  logic [IDX-1:0]     req_idx_s;
  logic [TAG_W-1:0]   req_tag_s;
  logic [IDX-1:0]     acc_idx_s;
  logic               vic_valid_s, vic_dirty_s, tag_hit_s;
  logic [TAG_W-1:0]   vic_tag_s;
  logic [31:0]        vic_data_s;
  logic               line_we_s;
  logic [31:0]        line_data_s;
  logic               unused_s;

  // Byte-offset bits of the address carry no information for word lines.
  assign unused_s = ^cpu_addr[1:0];

  assign req_idx_s = req_word_r[IDX-1:0];
  assign req_tag_s = req_word_r[29:IDX];

  // Select the line under inspection: the flush cursor while flushing, otherwise the request index.
  always_comb begin
    if ((state_r == FLUSH) || flushing_r) begin
      acc_idx_s = flush_idx_r;
    end else begin
      acc_idx_s = req_idx_s;
    end
  end

  assign vic_valid_s = valid_r[acc_idx_s];
  assign vic_dirty_s = dirty_r[acc_idx_s];
  assign vic_tag_s   = tag_mem_r[acc_idx_s];
  assign vic_data_s  = data_mem_r[acc_idx_s];
  assign tag_hit_s   = vic_valid_s && (vic_tag_s == req_tag_s);

  // Decide when the tag/data store for the request index is written and with which data.
  always_comb begin
    line_we_s   = 1'b0;
    line_data_s = req_wdata_r;
    case (state_r)
      COMPARE: begin
        if (req_we_r && (tag_hit_s || !(vic_valid_s && vic_dirty_s))) begin
          line_we_s = 1'b1;
        end else begin
          line_we_s = 1'b0;
        end
      end
      WRITEBACK: begin
        if (mem_req_r && mem_ack && !flushing_r && req_we_r) begin
          line_we_s = 1'b1;
        end else begin
          line_we_s = 1'b0;
        end
      end
      REFILL: begin
        if (mem_req_r && mem_ack) begin
          line_we_s   = 1'b1;
          line_data_s = mem_rdata;
        end else begin
          line_we_s = 1'b0;
        end
      end
      default: line_we_s = 1'b0;
    endcase
  end

  // Tag and data storage; validity is tracked separately so these need no reset.
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      tag_mem_r[req_idx_s]  <= req_tag_s;
      data_mem_r[req_idx_s] <= line_data_s;
    end
  end

  // Controller FSM with registered CPU and memory side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      req_we_r     <= 1'b0;
      req_word_r   <= 30'd0;
      req_wdata_r  <= 32'd0;
      hit_r        <= 1'b0;
      rd_buf_r     <= 32'd0;
      flushing_r   <= 1'b0;
      flush_idx_r  <= '0;
      valid_r      <= '0;
      dirty_r      <= '0;
      cpu_ready_r  <= 1'b0;
      cpu_hit_r    <= 1'b0;
      cpu_rdata_r  <= 32'd0;
      flush_done_r <= 1'b0;
      busy_r       <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
    end else begin
      cpu_ready_r  <= 1'b0;
      flush_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (flush) begin
            flush_idx_r <= '0;
            busy_r      <= 1'b1;
            state_r     <= FLUSH;
          end else if (cpu_req) begin
            req_we_r    <= cpu_we;
            req_word_r  <= cpu_addr[31:2];
            req_wdata_r <= cpu_wdata;
            busy_r      <= 1'b1;
            state_r     <= COMPARE;
          end
        end
        COMPARE: begin
          if (tag_hit_s) begin
            hit_r <= 1'b1;
            if (req_we_r) begin
              dirty_r[req_idx_s] <= 1'b1;
            end else begin
              rd_buf_r <= vic_data_s;
            end
            state_r <= DONE;
          end else begin
            hit_r <= 1'b0;
            if (vic_valid_s && vic_dirty_s) begin
              state_r <= WRITEBACK;
            end else if (!req_we_r) begin
              state_r <= REFILL;
            end else begin
              valid_r[req_idx_s] <= 1'b1;
              dirty_r[req_idx_s] <= 1'b1;
              state_r            <= DONE;
            end
          end
        end
        WRITEBACK: begin
          if (!mem_req_r) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= {vic_tag_s, acc_idx_s, 2'b00};
            mem_wdata_r <= vic_data_s;
          end else if (mem_ack) begin
            mem_req_r          <= 1'b0;
            mem_we_r           <= 1'b0;
            dirty_r[acc_idx_s] <= 1'b0;
            if (flushing_r) begin
              flushing_r <= 1'b0;
              if (flush_idx_r == LAST_IDX) begin
                flush_done_r <= 1'b1;
                busy_r       <= 1'b0;
                state_r      <= IDLE;
              end else begin
                flush_idx_r <= flush_idx_r + ONE_IDX;
                state_r     <= FLUSH;
              end
            end else if (req_we_r) begin
              valid_r[req_idx_s] <= 1'b1;
              dirty_r[req_idx_s] <= 1'b1;
              state_r            <= DONE;
            end else begin
              state_r <= REFILL;
            end
          end
        end
        REFILL: begin
          if (!mem_req_r) begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {req_tag_s, req_idx_s, 2'b00};
          end else if (mem_ack) begin
            mem_req_r          <= 1'b0;
            valid_r[req_idx_s] <= 1'b1;
            dirty_r[req_idx_s] <= 1'b0;
            rd_buf_r           <= mem_rdata;
            state_r            <= DONE;
          end
        end
        FLUSH: begin
          if (vic_valid_s && vic_dirty_s) begin
            flushing_r <= 1'b1;
            state_r    <= WRITEBACK;
          end else if (flush_idx_r == LAST_IDX) begin
            flush_done_r <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end else begin
            flush_idx_r <= flush_idx_r + ONE_IDX;
          end
        end
        DONE: begin
          cpu_ready_r <= 1'b1;
          cpu_hit_r   <= hit_r;
          if (!req_we_r) begin
            cpu_rdata_r <= rd_buf_r;
          end
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ready  = cpu_ready_r;
  assign cpu_hit    = cpu_hit_r;
  assign cpu_rdata  = cpu_rdata_r;
  assign flush_done = flush_done_r;
  assign busy       = busy_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Scoreboard bench for wb_cache_ctrl: a direct-mapped cache model predicts
// CPU responses and memory transactions; monitors compare as the DUT responds.
module tb_wb_cache_ctrl;

  localparam int DEPTH = 64;

  logic        clk, reset;
  logic        cpu_req, cpu_we, cpu_ready, cpu_hit;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        flush, flush_done, busy;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  wb_cache_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {logic hit; logic [31:0] rdata;} cpu_exp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  // Reference model: what the cache holds, what each address architecturally contains.
  bit          m_valid [DEPTH];
  bit          m_dirty [DEPTH];
  logic [23:0] m_tag   [DEPTH];
  logic [31:0] shadow  [logic [31:0]];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] last_rdata;
  int          exp_flush_done = 0;
  int          got_flush_done = 0;
  bit          hold_ack = 1'b0;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'h5EED_1234;
  endfunction

  function automatic logic [31:0] arch_val(logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  task automatic model_req(input bit we, input logic [31:0] a_in, input logic [31:0] wd, output bit hit);
    logic [31:0] a, va;
    logic [5:0]  ix;
    logic [23:0] tg;
    a  = a_in & 32'hFFFF_FFFC;
    ix = a[7:2];
    tg = a[31:8];
    hit = m_valid[ix] && (m_tag[ix] == tg);
    if (!hit) begin
      if (m_valid[ix] && m_dirty[ix]) begin
        va = {m_tag[ix], ix, 2'b00};
        mem_q.push_back('{we: 1'b1, addr: va, wdata: arch_val(va)});
      end
      if (!we) mem_q.push_back('{we: 1'b0, addr: a, wdata: 32'd0});
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
      m_dirty[ix] = 1'b0;
    end
    if (we) begin
      shadow[a]   = wd;
      m_dirty[ix] = 1'b1;
    end else begin
      last_rdata = arch_val(a);
    end
    cpu_q.push_back('{hit: hit, rdata: last_rdata});
  endtask

  task automatic model_flush();
    logic [31:0] va;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        va = {m_tag[i], 6'(i), 2'b00};
        mem_q.push_back('{we: 1'b1, addr: va, wdata: arch_val(va)});
        m_dirty[i] = 1'b0;
      end
    end
    exp_flush_done++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_dirty[i]) shadow.delete({m_tag[i], 6'(i), 2'b00});
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    last_rdata = 32'd0;
    cpu_q.delete();
    mem_q.delete();
  endtask

  // CPU-side monitor: pops the expected completion whenever cpu_ready is seen.
  initial begin
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && cpu_ready) begin
        if (cpu_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_cpu_ready: got ready with empty queue, required none");
        end else begin
          e = cpu_q.pop_front();
          check("cpu_hit", {31'd0, cpu_hit}, {31'd0, e.hit});
          check("cpu_rdata", cpu_rdata, e.rdata);
        end
      end
      if (!reset && flush_done) got_flush_done++;
    end
  end

  // Memory responder and monitor: random ack delay, compares each transaction at its ack.
  initial begin
    bit          active;
    int          dly;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    mem_exp_t    e;
    active = 1'b0; dly = 0; lat_we = 1'b0; lat_addr = 32'd0; lat_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ack = 1'b0;
        active  = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req && !hold_ack) begin
        if (!active) begin
          active = 1'b1; lat_we = mem_we; lat_addr = mem_addr; lat_wdata = mem_wdata;
          dly = $urandom_range(0, 3);
        end
        if (dly == 0) begin
          check("mem_stable", {31'd0, (mem_we === lat_we) && (mem_addr === lat_addr) && (mem_wdata === lat_wdata)}, 32'd1);
          if (mem_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_mem_req: got we=%0b addr %h, required no access", mem_we, mem_addr);
          end else begin
            e = mem_q.pop_front();
            check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            check("mem_addr", mem_addr, e.addr);
            if (e.we) begin
              check("mem_wdata", mem_wdata, e.wdata);
              mem[e.addr] = e.wdata;
            end
          end
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
          mem_ack = 1'b1;
          active  = 1'b0;
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit hit;
    int n;
    model_req(we, a, wd, hit);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!cpu_ready && n < 300);
    check("req_completes", {31'd0, cpu_ready}, 32'd1);
    if (hit) check("hit_latency", n, 32'd3);
    cpu_req = 1'b0;
  endtask

  task automatic do_flush();
    int n;
    model_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!flush_done && n < 3000);
    check("flush_done_seen", {31'd0, flush_done}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit          hit;
    int          n;
    logic [31:0] a;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; flush = 1'b0;
    last_rdata = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_cpu_hit", {31'd0, cpu_hit}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    mem[32'h0000_0010] = 32'hDEAD_BEEF;

    // Read miss then read hit.
    do_req(1'b0, 32'h0000_0010, 32'd0);
    check("miss_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("miss_hit", {31'd0, cpu_hit}, 32'd0);
    do_req(1'b0, 32'h0000_0010, 32'd0);
    check("hit_flag", {31'd0, cpu_hit}, 32'd1);

    // Write miss allocates without memory, read back hits.
    do_req(1'b1, 32'hAAAA_A028, 32'h1234_5678);
    check("wmiss_hit", {31'd0, cpu_hit}, 32'd0);
    do_req(1'b0, 32'hAAAA_A028, 32'd0);
    check("wmiss_readback", cpu_rdata, 32'h1234_5678);

    // Conflicting write evicts dirty line; read back evicts again and refills.
    do_req(1'b1, 32'hBBBB_B028, 32'h8765_4321);
    do_req(1'b0, 32'hAAAA_A028, 32'd0);
    check("evict_readback", cpu_rdata, 32'h1234_5678);

    // Flush with dirty lines at indices 3 and 5, then both re-read as hits.
    do_req(1'b1, 32'h0000_000C, 32'h0303_0303);
    do_req(1'b1, 32'h0000_0014, 32'h0505_0505);
    check("two_wb_pending", mem_q.size(), 32'd0);
    do_flush();
    do_req(1'b0, 32'h0000_000C, 32'd0);
    do_req(1'b0, 32'h0000_0014, 32'd0);

    // Flush and request in the same cycle: flush finishes first.
    do_req(1'b1, 32'h0000_0100, 32'hCAFE_0001);
    model_flush();
    model_req(1'b0, 32'h0000_0010, 32'd0, hit);
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    @(negedge clk); flush = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!cpu_ready && n < 3000);
    check("simul_req_done", {31'd0, cpu_ready}, 32'd1);
    check("flush_before_req", got_flush_done, exp_flush_done);
    cpu_req = 1'b0;

    // Randomized traffic over a few conflicting tags and indices.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_flush();
      end else begin
        a = {24'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        do_req(1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    // Reset in the middle of a writeback abandons it.
    do_req(1'b1, 32'h0000_0224, 32'h2424_2424);
    hold_ack = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0324;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!mem_req && n < 50);
    check("wb_started", {31'd0, mem_req && mem_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_drops_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_drops_busy", {31'd0, busy}, 32'd0);
    cpu_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    hold_ack = 1'b0;
    reset = 1'b0;
    do_req(1'b0, 32'h0000_0224, 32'd0);
    check("post_rst_miss", {31'd0, cpu_hit}, 32'd0);
    do_req(1'b0, 32'h0000_0010, 32'd0);
    do_req(1'b0, 32'hAAAA_A028, 32'd0);

    repeat (10) @(negedge clk);
    check("cpu_q_drained", cpu_q.size(), 32'd0);
    check("mem_q_drained", mem_q.size(), 32'd0);
    check("flush_done_count", got_flush_done, exp_flush_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
